// File: rtl/l1_l2_line_adaptor_pkg.sv
// Shared LC-3b line/word types, adaptor state encoding and half-line helpers
// for the L1 (128 b) to L2 (256 b) line adaptor.
package l1_l2_line_adaptor_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_L1_line;
  typedef logic [255:0] lc3b_L2_line;
  typedef logic [10:0]  lc3b_L2_tag_full;

  localparam int L2_HALF_BIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    RESP
  } lc3b_adaptor_state;

  // Half 0 is bits [127:0] of the L2 line, half 1 is bits [255:128].
  function automatic lc3b_L2_line merge_half(input lc3b_L2_line line,
                                             input logic        half,
                                             input lc3b_L1_line data);
    lc3b_L2_line merged;
    merged = line;
    if (half) merged[255:128] = data;
    else      merged[127:0]   = data;
    return merged;
  endfunction

  function automatic lc3b_L1_line select_half(input lc3b_L2_line line,
                                              input logic        half);
    return half ? line[255:128] : line[127:0];
  endfunction

endpackage

// File: rtl/l1_l2_line_adaptor_if.sv
// L1-side and L2-side line ports of the adaptor. slave = adaptor view,
// master = view of the surrounding L1 cache / L2 cache.
interface l1_l2_line_adaptor_if;
  import l1_l2_line_adaptor_pkg::*;

  logic        l1_read;
  logic        l1_write;
  lc3b_word    l1_address;
  lc3b_L1_line l1_wdata;
  lc3b_L1_line l1_rdata;
  logic        l1_resp;

  logic        l2_read;
  logic        l2_write;
  lc3b_word    l2_address;
  lc3b_L2_line l2_wdata;
  lc3b_L2_line l2_rdata;
  logic        l2_resp;

  modport slave (
    input  l1_read, l1_write, l1_address, l1_wdata, l2_rdata, l2_resp,
    output l1_rdata, l1_resp, l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output l1_read, l1_write, l1_address, l1_wdata, l2_rdata, l2_resp,
    input  l1_rdata, l1_resp, l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/l1_l2_line_adaptor_l2_line_buffer.sv
// Single-entry L2 line buffer: tag, valid, 256-bit data, hit compare and
// half merge/select. Hit is live only with LC3B_L2_LINE_BUFFER_EN defined.
module l2_line_buffer
  import l1_l2_line_adaptor_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            merge_en,
  input  lc3b_L2_line     fill_data,
  input  lc3b_L2_tag_full fill_tag,
  input  lc3b_L2_tag_full lookup_tag,
  input  logic            merge_sel,
  input  lc3b_L1_line     merge_data,
  input  logic            read_sel,
  output logic            hit,
  output lc3b_L2_line     line,
  output lc3b_L1_line     read_half
);

  logic            valid_q;
  lc3b_L2_tag_full tag_q;
  lc3b_L2_line     data_q;

  // A fill that belongs to a write merges the new half in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= merge_en ? merge_half(fill_data, merge_sel, merge_data) : fill_data;
    end else if (merge_en) begin
      data_q  <= merge_half(data_q, merge_sel, merge_data);
    end
  end

`ifdef LC3B_L2_LINE_BUFFER_EN
  assign hit = valid_q && (tag_q == lookup_tag);
`else
  logic unused_lookup;
  assign hit           = 1'b0;
  assign unused_lookup = ^{valid_q, tag_q, lookup_tag};
`endif

  assign line      = data_q;
  assign read_half = select_half(data_q, read_sel);

endmodule

// File: rtl/l1_l2_line_adaptor.sv
// Adapts 128-bit L1 line requests to 256-bit L2 line transactions with
// read-merge-write. Optional line buffer: define LC3B_L2_LINE_BUFFER_EN.
module l1_l2_line_adaptor
  import l1_l2_line_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  l1_l2_line_adaptor_if.slave    bus
);

  lc3b_adaptor_state state, next_state;
  lc3b_word          addr_q;
  lc3b_L1_line       wdata_q;
  logic              is_write;

  logic              request;
  logic              buf_hit;
  logic              buf_load;
  logic              buf_merge;
  logic              merge_sel;
  lc3b_L1_line       merge_data;
  lc3b_L2_line       buf_line;
  lc3b_L1_line       buf_half;

  assign request = bus.l1_read | bus.l1_write;

  // In IDLE the hit check and a write-hit merge act on the live request,
  // since addr_q/wdata_q are only latched on that same edge.
  assign merge_sel  = (state == IDLE) ? bus.l1_address[L2_HALF_BIT] : addr_q[L2_HALF_BIT];
  assign merge_data = (state == IDLE) ? bus.l1_wdata : wdata_q;

  l2_line_buffer u_line_buffer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (buf_load),
    .merge_en   (buf_merge),
    .fill_data  (bus.l2_rdata),
    .fill_tag   (addr_q[15:L2_HALF_BIT+1]),
    .lookup_tag (bus.l1_address[15:L2_HALF_BIT+1]),
    .merge_sel  (merge_sel),
    .merge_data (merge_data),
    .read_sel   (addr_q[L2_HALF_BIT]),
    .hit        (buf_hit),
    .line       (buf_line),
    .read_half  (buf_half)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_write <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && request) begin
        addr_q   <= bus.l1_address;
        wdata_q  <= bus.l1_wdata;
        is_write <= bus.l1_write;
      end
    end
  end

  always_comb begin
    next_state = state;
    buf_load   = 1'b0;
    buf_merge  = 1'b0;
    unique case (state)
      IDLE: begin
        if (request) begin
          if (buf_hit) begin
            buf_merge  = bus.l1_write;
            next_state = bus.l1_write ? WRITE : RESP;
          end else begin
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.l2_resp) begin
          buf_load   = 1'b1;
          buf_merge  = is_write;
          next_state = is_write ? WRITE : RESP;
        end
      end
      WRITE: begin
        if (bus.l2_resp) next_state = RESP;
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.l1_resp    = (state == RESP);
  assign bus.l1_rdata   = (state == RESP) ? buf_half : '0;
  assign bus.l2_read    = (state == FETCH);
  assign bus.l2_write   = (state == WRITE);
  assign bus.l2_address = {addr_q[15:L2_HALF_BIT+1], 5'b0};
  assign bus.l2_wdata   = (state == WRITE) ? buf_line : '0;

endmodule
